four_bit_adder_subtractor: RTL and testbench

FOUR_BIT_ADDER_SUBTRACTOR -- requirements
Module: four_bit_adder_subtractor

---
 rtl/four_bit_adder_subtractor.sv | 80 ++++++++
 tb/tb_four_bit_adder_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/four_bit_adder_subtractor.sv
// Registered 4-bit ripple-carry adder/subtractor with one-cycle latency.
// Optional signed-overflow flag enabled by defining ADD_SUB_OVERFLOW_EN.
module four_bit_adder_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       m,
  input  logic       in_valid,
  output logic [3:0] Sum,
  output logic       Carry,
  output logic       Overflow,
  output logic       out_valid
);

  logic [3:0] b_x;
  logic [3:0] s;
  logic [4:0] c;

  // Subtraction is A + ~B + 1: invert B with m and inject m as carry-in.
  assign c[0] = m;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign b_x[gi]  = B[gi] ^ m;
      assign s[gi]    = A[gi] ^ b_x[gi] ^ c[gi];
      assign c[gi+1]  = (A[gi] & b_x[gi]) | (c[gi] & (A[gi] ^ b_x[gi]));
    end
  endgenerate

  logic [3:0] sum_q, sum_d;
  logic       carry_q, carry_d;
  logic       valid_q, valid_d;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 4'b0000;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

`ifdef ADD_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = c[3] ^ c[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// Directed and exhaustive checks for four_bit_adder_subtractor.
// Overflow expectations follow whether ADD_SUB_OVERFLOW_EN is defined.
module tb_four_bit_adder_subtractor;

`ifdef ADD_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic       m = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] Sum;
  logic       Carry;
  logic       Overflow;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  four_bit_adder_subtractor dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .m(m), .in_valid(in_valid),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: {out_valid, Carry, Sum, Overflow} for a sampled operation.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic mm);
    logic [4:0] r;
    logic       v;
    if (mm) begin
      r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      v = (a[3] != b[3]) && (r[3] != a[3]);
    end else begin
      r = {1'b0, a} + {1'b0, b};
      v = (a[3] == b[3]) && (r[3] != a[3]);
    end
    return {1'b1, r[4], r[3:0], v & OVF_EN};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, Carry, Sum, Overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", {out_valid, Carry, Sum, Overflow}, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_directed();
    // {A, B, m, expected {out_valid, Carry, Sum, Overflow}}
    logic [15:0] vec [8];
    vec[0] = {4'b1101, 4'b0011, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0};
    vec[1] = {4'b1111, 4'b0011, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0};
    vec[2] = {4'b1001, 4'b0011, 1'b1, 1'b1, 1'b1, 4'b0110, OVF_EN};
    vec[3] = {4'b0011, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b1110, 1'b0};
    vec[4] = {4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1000, OVF_EN};
    vec[5] = {4'b1111, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0};
    vec[6] = {4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0};
    vec[7] = {4'b0101, 4'b0101, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      A = vec[i][15:12]; B = vec[i][11:8]; m = vec[i][7]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, Carry, Sum, Overflow} !== vec[i][6:0]) begin
        errors++;
        $display("FAIL directed_%0d: A=%b B=%b m=%b got %b expected %b",
                 i, vec[i][15:12], vec[i][11:8], vec[i][7],
                 {out_valid, Carry, Sum, Overflow}, vec[i][6:0]);
      end
      $display("directed %0d: A=%b B=%b m=%b -> %b", i, vec[i][15:12], vec[i][11:8], vec[i][7],
               {out_valid, Carry, Sum, Overflow});
    end
  endtask

  task automatic test_hold();
    logic [6:0] held;
    @(negedge clk);
    A = 4'b1001; B = 4'b0011; m = 1'b1; in_valid = 1'b1;
    held = model(4'b1001, 4'b0011, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Carry, Sum, Overflow} !== held) begin
      errors++;
      $display("FAIL hold_load: got %b expected %b", {out_valid, Carry, Sum, Overflow}, held);
    end
    // Operands and mode move while idle; outputs must not follow them.
    for (int i = 0; i < 3; i++) begin
      A = 4'(i + 3); B = 4'(i * 5); m = ~m;
      @(negedge clk);
      checks++;
      if ({out_valid, Carry, Sum, Overflow} !== {1'b0, held[5:0]}) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got %b expected %b", i,
                 {out_valid, Carry, Sum, Overflow}, {1'b0, held[5:0]});
      end
      $display("hold %0d: outputs %b", i, {out_valid, Carry, Sum, Overflow});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    A = 4'b0111; B = 4'b0110; m = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    checks++;
    if ({Carry, Sum} !== 5'b01101) begin
      errors++;
      $display("FAIL async_pre: got %b expected %b", {Carry, Sum}, 5'b01101);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Carry, Sum, Overflow} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {out_valid, Carry, Sum, Overflow}, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, Carry, Sum, Overflow} !== 7'b0) begin
      errors++;
      $display("FAIL async_release: got %b expected %b", {out_valid, Carry, Sum, Overflow}, 7'b0);
    end
    $display("async reset: outputs %b after release", {out_valid, Carry, Sum, Overflow});
  endtask

  task automatic test_back_to_back();
    logic [8:0] v;
    logic [8:0] prev;
    logic [6:0] exp;
    prev = 9'd0;
    for (int i = 0; i <= 512; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = model(prev[8:5], prev[4:1], prev[0]);
        checks++;
        if ({out_valid, Carry, Sum, Overflow} !== exp) begin
          errors++;
          $display("FAIL sweep: A=%b B=%b m=%b got %b expected %b",
                   prev[8:5], prev[4:1], prev[0], {out_valid, Carry, Sum, Overflow}, exp);
        end
      end
      if (i < 512) begin
        v = 9'(i);
        A = v[8:5]; B = v[4:1]; m = v[0]; in_valid = 1'b1;
        prev = v;
      end else begin
        in_valid = 1'b0;
      end
    end
    $display("sweep: 512 back-to-back operations compared");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
